// File: rtl/ped_btn_conditioner.sv
// Pedestrian push-button conditioner: 2-FF sync, debounce, rise strobe, latched request FSM.
// Latency: clean btn_raw step -> btn_db after 2+DEB_CYCLES edges, btn_req one edge after btn_pulse.
// No backpressure: request is held until ped_green rises; optional macro PED_BTN_QUEUE_EN queues a press seen during SERVE.
module ped_btn_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             ped_green,
    output logic             btn_req,
    output logic             btn_db,
    output logic             btn_pulse,
    output logic [CNT_W-1:0] press_cnt,
    output logic [1:0]       req_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             db_q, db_d;
    logic             pulse_q, pulse_d;
    logic             pg_q;
    logic             pg_vld_q;
    logic             pg_rise, pg_fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_inc;
`ifdef PED_BTN_QUEUE_EN
    logic             queue_q, queue_d;
`endif

    // Debounce: count cycles of disagreement, flip the level once it has persisted DEB_CYCLES cycles.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        db_d      = db_q;
        pulse_d   = 1'b0;
        if (s2_q != db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                db_d      = s2_q;
                deb_cnt_d = '0;
                pulse_d   = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
    end

    // pg_vld_q masks the first cycle after reset so a ped_green already high is not seen as a rise.
    assign pg_rise = pg_vld_q & ped_green & ~pg_q;
    assign pg_fall = pg_vld_q & ~ped_green & pg_q;

    // Request FSM next state; a ped_green rise always wins over a simultaneous press.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
`ifdef PED_BTN_QUEUE_EN
        queue_d = queue_q;
`endif
        case (state_q)
            IDLE: begin
                if (pg_rise) begin
                    state_d = SERVE;
                end else if (pulse_q) begin
                    state_d = REQ;
                    cnt_inc = 1'b1;
                end
            end
            REQ: begin
                if (pg_rise) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
`ifdef PED_BTN_QUEUE_EN
                if (pg_fall) begin
                    // A press arriving on the same cycle as the fall is treated as queued.
                    if (queue_q || pulse_q) begin
                        state_d = REQ;
                        queue_d = 1'b0;
                        cnt_inc = ~queue_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pulse_q && !queue_q) begin
                    queue_d = 1'b1;
                    cnt_inc = 1'b1;
                end
`else
                if (pg_fall) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating accepted-press counter.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // All state registers; synchronous reset takes priority over every event.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            deb_cnt_q <= '0;
            db_q      <= 1'b0;
            pulse_q   <= 1'b0;
            pg_q      <= 1'b0;
            pg_vld_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
`ifdef PED_BTN_QUEUE_EN
            queue_q   <= 1'b0;
`endif
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            deb_cnt_q <= deb_cnt_d;
            db_q      <= db_d;
            pulse_q   <= pulse_d;
            pg_q      <= ped_green;
            pg_vld_q  <= 1'b1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
`ifdef PED_BTN_QUEUE_EN
            queue_q   <= queue_d;
`endif
        end
    end

    assign btn_req   = (state_q == REQ);
    assign btn_db    = db_q;
    assign btn_pulse = pulse_q;
    assign press_cnt = cnt_q;
    assign req_state = state_q;

endmodule

// File: doc/ped_btn_conditioner.md
Name: ped_btn_conditioner

Overview:
Input stage for the pedestrian crossing. It takes the raw, asynchronous, bouncy push-button and produces a clean, latched crossing request for the downstream pedestrian traffic-light FSM's btn input. The request stays high until the light reports that pedestrian green has started. It sits between the board pin and the traffic-light controller, in the controller's clock domain.

Parameters:
DEB_CYCLES, 4, consecutive clk cycles the synchronised button must differ from the debounced level before that level flips (min 2)
DEB_W, 3, width of the debounce counter; must satisfy 2^DEB_W > DEB_CYCLES
CNT_W, 8, width of the accepted-press statistics counter

Ports:
clk  input  1  system clock, same clock as the traffic-light controller
rst  input  1  synchronous reset, active-high
btn_raw  input  1  raw push-button pin, asynchronous, may bounce
ped_green  input  1  pedestrian green LED level fed back from the controller
btn_req  output  1  latched crossing request; drives the controller's btn
btn_db  output  1  debounced button level
btn_pulse  output  1  one-cycle strobe on each debounced rising edge
press_cnt  output  CNT_W  number of presses accepted into a request; saturating
req_state  output  2  FSM state for debug: 0 IDLE, 1 REQ, 2 SERVE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: sync FFs=0, deb counter=0, btn_db=0, btn_pulse=0, btn_req=0, press_cnt=0, state=IDLE, ped_green edge register=0. Reset has priority over all events, including in mid-debounce and in mid-request.
- Synchroniser: 2-FF chain btn_raw -> s1 -> s2. Only s2 is used downstream.
- Debounce:
  - If s2 != btn_db, the counter increments; otherwise it clears.
  - When the counter is at DEB_CYCLES-1 and s2 != btn_db, the next edge loads btn_db <= s2 and clears the counter.
  - Net latency from a clean step on btn_raw to btn_db: 2+DEB_CYCLES edges.
  - A glitch shorter than DEB_CYCLES cycles at s2 produces no change.
- btn_pulse: registered, high for exactly the one cycle in which btn_db first reads 1. A release never pulses.
- ped_green edge detect: pg_d is ped_green delayed one cycle.
  - pg_rise = ped_green & ~pg_d.
  - pg_fall = ~ped_green & pg_d.
- FSM (registered; btn_req = state==REQ, registered):
  - IDLE: btn_pulse -> REQ and press_cnt+1. pg_rise -> SERVE; this covers a cycle forced by the controller's own timeout.
  - REQ: btn_pulse is ignored and not counted. pg_rise -> SERVE.
  - SERVE: btn_pulse is ignored (see optional feature). pg_fall -> IDLE.
- Latency: btn_req goes high on the edge after btn_pulse is high. It drops on the edge after ped_green rises.
- Simultaneous events:
  - btn_pulse with pg_rise in IDLE -> SERVE, press not counted.
  - ped_green already high when leaving reset -> no pg_rise, so the block stays in IDLE; a press there is accepted.
- press_cnt saturates at 2^CNT_W-1 and does not wrap.
- Illegal state 3 -> IDLE on the next edge.

Optional Feature:
Macro PED_BTN_QUEUE_EN.
- Defined: a 1-bit queue flag is set by a btn_pulse in SERVE, and that press is counted. On pg_fall with the flag set -> REQ directly, with the flag cleared. Reset clears the flag.
- Undefined: presses in SERVE are dropped and uncounted, and no flag logic exists.

Test Plan:
All scenarios use DEB_CYCLES=4.
1. Reset then clean press: btn_raw=1 after edge 0 -> btn_db=1 and btn_pulse=1 after edge 6, btn_pulse=0 after edge 7, btn_req=1 after edge 7, press_cnt=1, req_state=1.
2. Bounce: btn_raw toggles 1,0,1,0 each cycle, then a 3-cycle-high glitch -> btn_db, btn_pulse and btn_req stay 0 throughout, press_cnt=0.
3. Service handshake: in REQ, drive ped_green 0->1 -> btn_req=0 and req_state=2 one edge later. Drive ped_green 1->0 -> req_state=0.
4. Presses in REQ and SERVE: three more clean presses while in REQ/SERVE -> press_cnt stays 1. With PED_BTN_QUEUE_EN, a press in SERVE -> press_cnt=2, and req_state=1 with btn_req=1 the edge after ped_green falls.
5. Collision and reset: btn_pulse in the same cycle as ped_green rises -> SERVE, press_cnt unchanged. Assert rst for one cycle while in REQ -> all outputs 0 and req_state=0 next edge.
6. Saturation: with CNT_W=2, run 5 accepted request/service cycles -> press_cnt reads 1,2,3,3,3.
